// File: rtl/imem_boot_loader.sv
// Byte-stream program loader: packs header-counted MSB-first bytes into 32-bit words written from address 0.
// A word is written the cycle after its 4th byte; rx_ready is low in CHECK/WRITE/DONE/ERROR, and the core stays in reset until DONE.
module imem_boot_loader #(
   parameter int INSTRUCTION_WIDTH = 32,
   parameter int MAX_WORDS         = 256
) (
   input  logic                         CLK,
   input  logic                         Reset,
   input  logic [7:0]                   rx_data,
   input  logic                         rx_valid,
   output logic                         rx_ready,
   output logic                         IMemWE,
   output logic [INSTRUCTION_WIDTH-1:0] IMemA,
   output logic [INSTRUCTION_WIDTH-1:0] IMemWD,
   output logic                         core_reset_n,
   output logic                         done,
   output logic                         error
);

   localparam logic [2:0] HDR_HI = 3'd0;
   localparam logic [2:0] HDR_LO = 3'd1;
   localparam logic [2:0] CHECK  = 3'd2;
   localparam logic [2:0] LOAD   = 3'd3;
   localparam logic [2:0] WRITE  = 3'd4;
   localparam logic [2:0] DONE   = 3'd5;
   localparam logic [2:0] ERROR  = 3'd6;

   localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

   logic [2:0]                   state_q, state_d;
   logic [15:0]                  word_count_q, word_count_d;
   logic [15:0]                  word_idx_q, word_idx_d;
   logic [1:0]                   byte_cnt_q, byte_cnt_d;
   logic [INSTRUCTION_WIDTH-1:0] asm_q, asm_d;
   logic                         rx_ready_q, we_q, done_q, error_q, core_rst_n_q;
   logic [INSTRUCTION_WIDTH-1:0] imem_a_q, imem_wd_q;
   logic [17:0]                  byte_addr;
   logic                         xfer;

   assign xfer      = rx_valid && rx_ready_q;
   assign byte_addr = {word_idx_q, 2'b00};

   always_comb begin
      state_d      = state_q;
      word_count_d = word_count_q;
      word_idx_d   = word_idx_q;
      byte_cnt_d   = byte_cnt_q;
      asm_d        = asm_q;
      case (state_q)
         HDR_HI: if (xfer) begin
            word_count_d[15:8] = rx_data;
            state_d            = HDR_LO;
         end
         HDR_LO: if (xfer) begin
            word_count_d[7:0] = rx_data;
            state_d           = CHECK;
         end
         CHECK: begin
            if (word_count_q == 16'd0 || word_count_q > MAX_N) begin
               state_d = ERROR;
            end else begin
               state_d    = LOAD;
               word_idx_d = 16'd0;
               byte_cnt_d = 2'd0;
            end
         end
         LOAD: if (xfer) begin
            asm_d      = {asm_q[INSTRUCTION_WIDTH-9:0], rx_data};
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) state_d = WRITE;
         end
         WRITE: begin
            word_idx_d = word_idx_q + 16'd1;
            byte_cnt_d = 2'd0;
            state_d    = (word_idx_q + 16'd1 == word_count_q) ? DONE : LOAD;
         end
         default: state_d = state_q;
      endcase
   end

   // Output flops are loaded from the next state so they line up with the state register.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_q      <= HDR_HI;
         word_count_q <= '0;
         word_idx_q   <= '0;
         byte_cnt_q   <= '0;
         asm_q        <= '0;
         rx_ready_q   <= 1'b0;
         we_q         <= 1'b0;
         imem_a_q     <= '0;
         imem_wd_q    <= '0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         core_rst_n_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         word_count_q <= word_count_d;
         word_idx_q   <= word_idx_d;
         byte_cnt_q   <= byte_cnt_d;
         asm_q        <= asm_d;
         rx_ready_q   <= (state_d == HDR_HI) || (state_d == HDR_LO) || (state_d == LOAD);
         we_q         <= (state_d == WRITE);
         done_q       <= (state_d == DONE);
         error_q      <= (state_d == ERROR);
         core_rst_n_q <= (state_d == DONE);
         if (state_d == WRITE && state_q == LOAD) begin
            imem_a_q  <= INSTRUCTION_WIDTH'(byte_addr);
            imem_wd_q <= asm_d;
         end
      end
   end

   assign rx_ready     = rx_ready_q;
   assign IMemWE       = we_q;
   assign IMemA        = imem_a_q;
   assign IMemWD       = imem_wd_q;
   assign core_reset_n = core_rst_n_q;
   assign done         = done_q;
   assign error        = error_q;

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
Sits upstream of the instruction memory and the MIPS core. It receives a program image as a byte stream over a valid/ready interface and assembles it into 32-bit instruction words. It writes those words sequentially into instruction memory from address 0, and holds the core in reset until the whole image is loaded. Malformed images latch an error, and the core stays in reset.

Parameters:
INSTRUCTION_WIDTH, 32, instruction word width; fixed at 32 (4 bytes per word).
MAX_WORDS, 256, largest accepted image size in words; legal range 1..65535.

Ports:
CLK  input  1  system clock; all state updates on the rising edge.
Reset  input  1  asynchronous, active-low reset.
rx_data  input  8  incoming image byte.
rx_valid  input  1  rx_data is valid this cycle.
rx_ready  output  1  loader accepts a byte this cycle; a transfer occurs when rx_valid & rx_ready at the rising edge.
IMemWE  output  1  instruction-memory write enable, one-cycle pulse per word.
IMemA  output  INSTRUCTION_WIDTH  instruction-memory byte address (word_idx*4).
IMemWD  output  INSTRUCTION_WIDTH  instruction word to write.
core_reset_n  output  1  active-low reset to the core; released only after a successful load.
done  output  1  image loaded successfully.
error  output  1  image header rejected.

Behaviour:
- Clock and reset: one clock (CLK). Reset is asynchronous and active-low.
- Reset values: state=HDR_HI, rx_ready=0, IMemWE=0, IMemA=0, IMemWD=0, core_reset_n=0, done=0, error=0, word_count=0, word_idx=0, byte_cnt=0.
  - rx_ready is low during reset. It rises in the first cycle after deassertion (registered from state).
- Image format: 2-byte header N (word count, MSB first), then N words of 4 bytes each, MSB first. The first byte of each word goes to bits [31:24].
- HDR_HI: rx_ready=1. On transfer, word_count[15:8]=rx_data; go to HDR_LO.
- HDR_LO: rx_ready=1. On transfer, word_count[7:0]=rx_data; go to CHECK.
- CHECK (1 cycle, rx_ready=0):
  - N==0 or N>MAX_WORDS: go to ERROR.
  - Otherwise: go to LOAD with word_idx=0 and byte_cnt=0.
- LOAD: rx_ready=1.
  - Each transfer shifts rx_data into the assembly register (shift left by 8) and increments byte_cnt.
  - On the 4th byte, go to WRITE.
  - Cycles without rx_valid hold all state; gaps of any length are legal.
- WRITE (1 cycle, rx_ready=0): IMemWE=1, IMemA=word_idx*4 (zero-extended), IMemWD=assembled word.
  - Next edge: word_idx++ and byte_cnt=0.
  - If word_idx+1==N, go to DONE; else go to LOAD.
  - A byte presented with rx_valid=1 during WRITE is not consumed; the source holds it, and it is taken in the next LOAD cycle.
- DONE: rx_ready=0, done=1, core_reset_n=1. Terminal until Reset.
- ERROR: rx_ready=0, error=1, core_reset_n=0. Terminal until Reset.
- done and error are never both 1.
- IMemWE is 0 in every state except WRITE.
- Outputs are driven as Moore outputs of the state register. IMemA/IMemWD hold their last values outside WRITE.
- Reset mid-load: all state returns to reset values immediately and core_reset_n=0. Words already written to instruction memory are not erased. The next image is rewritten from address 0.
- Widths: word_idx is 16 bits. IMemA = {word_idx, 2'b00} truncated/zero-extended to INSTRUCTION_WIDTH.
- Throughput: 5 cycles per word minimum (4 accept + 1 write).
- Latency: last byte accepted → IMemWE on the next cycle → done/core_reset_n=1 on the cycle after.

Test Plan:
1. Happy path: stream 00 02 20 08 00 05 AC 01 00 04 with rx_valid held high.
   -> IMemWE pulses twice: (A=0x0, WD=0x20080005), then (A=0x4, WD=0xAC010004).
   -> done=1 and core_reset_n=1 one cycle after the second pulse; rx_ready=0 thereafter.
2. Zero count: header 00 00 -> error=1, core_reset_n=0, no IMemWE pulse, rx_ready=0 thereafter.
3. Oversize: MAX_WORDS=256, header 01 01 (257) -> error=1, no writes. Header 01 00 (256) is accepted and loads 256 words, last at IMemA=0x3FC.
4. Gapped stream with backpressure: N=1, rx_valid toggled randomly, and rx_valid=1 held through the WRITE cycle.
   -> Exactly one write with the correct word.
   -> Bytes are consumed only when rx_ready=1; no byte is dropped or duplicated.
5. Reset mid-load: assert Reset after 6 bytes of an N=3 image (first word written).
   -> Outputs return to reset values asynchronously.
   -> A fresh N=1 image then writes to IMemA=0x0, and done=1.
6. Post-done stimulus: keep driving rx_valid=1 after done -> rx_ready stays 0, no further IMemWE, done remains 1.
